mac_result_reader: RTL
======================

# mac_result_reader

Drains accumulated results from the MAC datapath and streams them off-chip one byte at a time. Each ACC_W-bit result is accepted on a valid/ready handshake into a small FIFO, then serialised least-significant byte first onto an 8-bit valid/ready byte port. The block sits between the MAC accumulators and the dedicated output pins, and exposes the full result instead of only its top byte.

## Interface
- ACC_W, 21: width of one accumulated result.
- DEPTH, 2: FIFO entries, power of two, at least 2.
- NBYTES, derived, ceil(ACC_W/8) = 3 at default: data bytes per result.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  global enable. Low means stall.
- res_valid  in  1  result available.
- res_data  in  ACC_W  result word.
- res_ready  out  1  block can accept a result.
- byte_out  out  8  current byte.
- byte_valid  out  1  byte_out is valid.
- byte_ready  in  1  consumer accepts the byte.
- byte_last  out  1  final byte of the current frame.
- busy  out  1  FIFO non-empty or frame in flight.

## Operation
- Push: occurs on a rising edge when res_valid & res_ready. res_ready = ena & rst_n & !full, combinational.
  - When the FIFO is full, res_ready stays low even if a pop happens in the same cycle. No bypass.
- FSM has two states:
  - IDLE: FIFO empty, byte_valid = 0.
  - SEND: byte_valid = 1, byte index idx runs 0..FRAME-1.
- IDLE -> SEND: on the edge after the FIFO becomes non-empty. Head entry is loaded into the shift register and idx = 0.
- Byte transfer: occurs on an edge when byte_valid & byte_ready & ena. idx increments and byte_out advances to the next byte.
- Last-byte transfer: pops the FIFO head.
  - If another entry remains or is pushed in the same cycle, it loads immediately with idx = 0 and the FSM stays in SEND (no bubble).
  - Otherwise the FSM returns to IDLE.
- Byte order: byte k = res_data[8k+7:8k]. The top byte is zero-extended; at ACC_W = 21 it carries bits [20:16] and bits [7:5] are 0.
- byte_last = 1 exactly when idx = FRAME-1 and byte_valid = 1. FRAME = NBYTES, or NBYTES+1 with parity enabled.
- Once byte_valid is asserted, byte_out, byte_valid and byte_last hold stable until the transfer completes.
- ena low:
  - No push, transfer, pop or state change occurs.
  - All registered outputs hold.
  - res_ready = 0.
- busy = (FIFO count != 0) | (state == SEND).

## Timing
- Reset, rst_n low at an edge: FIFO empty, state IDLE, idx = 0, byte_out = 0x00, byte_valid = 0, byte_last = 0, busy = 0.
  - While rst_n is low, res_ready = 0.
- Reset mid-frame discards the partial frame and all queued entries. No byte is repeated after reset.
- Latency: a result pushed at edge N into an empty, idle block gives byte_valid = 1 with byte 0 from edge N+1.
- Throughput: with byte_ready held high, one byte per cycle and FRAME cycles per result.
- Occupancy: the FIFO holds DEPTH entries, including the entry being serialised. Pointers wrap modulo DEPTH.
- Simultaneous push and last-byte pop when not full: count is unchanged and both actions take effect.

## Configuration
- MAC_RES_PARITY_EN defined: each frame gets one extra byte, the XOR of its NBYTES data bytes (padding included). byte_last is asserted on that parity byte. FRAME = NBYTES+1.
- MAC_RES_PARITY_EN undefined: FRAME = NBYTES, byte_last is asserted on the top data byte, and no parity logic is built.

## Test plan
- Single result: push 0x1ABCDE with byte_ready = 1 -> bytes 0xDE, 0xBC, 0x1A on consecutive cycles from N+1, byte_last on 0x1A, then busy = 0. With parity enabled, a fourth byte 0x78 carries byte_last.
- Backpressure: byte_ready low for 5 cycles mid-frame -> byte_out, byte_valid and byte_last hold. Bytes resume in order with none lost or duplicated.
- Full FIFO: push 0x000001, 0x000002 and 0x000003 with byte_ready = 0 -> res_ready drops after 2 pushes. The third result enters only after the first frame's last byte, then frames stream back-to-back with no idle cycle.
- ena stall: drop ena for 3 cycles mid-frame -> no progress, res_ready = 0, outputs hold. Stream continues correctly after ena returns.
- Reset mid-frame: assert rst_n low after byte 0 of 0x1ABCDE -> next edge gives byte_valid = 0, byte_out = 0x00, busy = 0. The next pushed result 0x0000FF emits 0xFF, 0x00, 0x00.
- Max value: push 0x1FFFFF -> bytes 0xFF, 0xFF, 0x1F. With parity enabled, the parity byte is 0x1F.

Source files
------------

// File: rtl/mac_result_reader.sv
// mac_result_reader: buffers ACC_W-bit MAC results in a small FIFO and
// streams each one off-chip least-significant byte first over an 8-bit
// valid/ready byte port.
// Optional feature: define MAC_RES_PARITY_EN to append one XOR parity byte
// to every frame (byte_last then marks the parity byte).
module mac_result_reader #(
  parameter int ACC_W = 21,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             res_valid,
  input  logic [ACC_W-1:0] res_data,
  output logic             res_ready,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             byte_last,
  output logic             busy
);

  localparam int NBYTES = (ACC_W + 7) / 8;
`ifdef MAC_RES_PARITY_EN
  localparam int FRAME  = NBYTES + 1;
`else
  localparam int FRAME  = NBYTES;
`endif
  localparam int FW     = FRAME * 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int IDX_W  = (FRAME > 1) ? $clog2(FRAME) : 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ACC_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    rd_ptr_nxt;
  logic [CNT_W-1:0]    count;
  logic [IDX_W-1:0]    idx;
  logic [FW-1:0]       shreg;
  logic                full;
  logic                push;
  logic                xfer;
  logic                last_xfer;
  logic                more;
  logic                load;
  logic [ACC_W-1:0]    load_data;
  logic [NBYTES*8-1:0] padded;
  logic [FW-1:0]       frame;
`ifdef MAC_RES_PARITY_EN
  logic [7:0]          parity;
`endif

  // Handshake qualifiers and output decode; a full FIFO refuses a result even
  // when the head is popped in the same cycle.
  always_comb begin
    full       = (count == CNT_W'(DEPTH));
    res_ready  = ena & rst_n & ~full;
    push       = res_valid & res_ready;
    byte_valid = (state_q == SEND);
    byte_last  = byte_valid & (idx == IDX_W'(FRAME - 1));
    byte_out   = shreg[7:0];
    busy       = (count != '0) | byte_valid;
    xfer       = ena & byte_valid & byte_ready;
    last_xfer  = xfer & byte_last;
    rd_ptr_nxt = rd_ptr + PTR_W'(1);
    more       = (count > CNT_W'(1)) | push;
  end

  // Next state and frame-load decision; a result pushed during the last-byte
  // pop is forwarded straight from res_data since it is not yet in memory.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_data = mem[rd_ptr];
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (count != '0) begin
            state_d = SEND;
            load    = 1'b1;
          end
        end
        SEND: begin
          if (last_xfer) begin
            if (more) begin
              load      = 1'b1;
              load_data = (count > CNT_W'(1)) ? mem[rd_ptr_nxt] : res_data;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Build the outgoing frame: zero-padded data bytes, plus parity if enabled.
  always_comb begin
    padded              = '0;
    padded[ACC_W-1:0]   = load_data;
`ifdef MAC_RES_PARITY_EN
    parity = 8'h00;
    for (int k = 0; k < NBYTES; k++) begin
      parity = parity ^ padded[8*k +: 8];
    end
    frame = {parity, padded};
`else
    frame = padded;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= res_data;
    end
  end

  // FIFO pointers and occupancy; the head is popped on its last byte transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (last_xfer) begin
        rd_ptr <= rd_ptr_nxt;
      end
      count <= count + CNT_W'(push) - CNT_W'(last_xfer);
    end
  end

  // Byte serialiser: load a frame, then shift one byte per accepted transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
      idx   <= '0;
    end else if (load) begin
      shreg <= frame;
      idx   <= '0;
    end else if (xfer) begin
      if (byte_last) begin
        idx <= '0;
      end else begin
        idx   <= idx + IDX_W'(1);
        shreg <= shreg >> 8;
      end
    end
  end

endmodule
